data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_if.sv | 49 ++++
 rtl/data_mem_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the CPU port (A), the loader/debug port (B) and the
// shared data memory. The arbiter takes the slave view; requesters and the
// memory model take the master view.
interface data_mem_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          A_Req;
  logic          A_Write;
  logic [AW-1:0] A_Addr;
  logic [DW-1:0] A_WData;
  logic          A_Gnt;
  logic          A_Valid;
  logic          A_Stall;
  logic [DW-1:0] A_RData;

  logic          B_Req;
  logic          B_Write;
  logic          B_Lock;
  logic [AW-1:0] B_Addr;
  logic [DW-1:0] B_WData;
  logic          B_Gnt;
  logic          B_Valid;
  logic [DW-1:0] B_RData;

  logic          Mem_Read;
  logic          Mem_Write;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] Mem_WData;
  logic [DW-1:0] Mem_RData;

  modport slave (
    input  A_Req, A_Write, A_Addr, A_WData,
    output A_Gnt, A_Valid, A_Stall, A_RData,
    input  B_Req, B_Write, B_Lock, B_Addr, B_WData,
    output B_Gnt, B_Valid, B_RData,
    output Mem_Read, Mem_Write, Mem_Addr, Mem_WData,
    input  Mem_RData
  );

  modport master (
    output A_Req, A_Write, A_Addr, A_WData,
    input  A_Gnt, A_Valid, A_Stall, A_RData,
    output B_Req, B_Write, B_Lock, B_Addr, B_WData,
    input  B_Gnt, B_Valid, B_RData,
    input  Mem_Read, Mem_Write, Mem_Addr, Mem_WData,
    output Mem_RData
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported, combinational-read data
// memory. Port A (CPU) and port B (loader/debug) share the memory; B can
// hold the memory for a bounded locked burst while A waits.
module data_mem_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_BURST = 4
) (
  input logic              Clk,
  input logic              Reset,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } lastGnt_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  lastGnt_t   lastGntReg;
  lastGnt_t   lastGntNext;
  logic [3:0] burstCntReg;
  logic [3:0] burstCntNext;
  logic       burstHold;
  logic       aGnt;
  logic       bGnt;

  // Arbitration state register; reset leaves B as last winner so A wins the first tie.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lastGntReg  <= LAST_B;
      burstCntReg <= 4'd0;
    end else begin
      lastGntReg  <= lastGntNext;
      burstCntReg <= burstCntNext;
    end
  end

  // Grant decision and next arbitration state from current requests.
  always_comb begin
    aGnt         = 1'b0;
    bGnt         = 1'b0;
    lastGntNext  = lastGntReg;
    burstCntNext = 4'd0;
    // B keeps the memory under lock only while it was the last winner and the burst budget remains.
    burstHold    = (lastGntReg == LAST_B) && bus.B_Lock && (burstCntReg < MAX_CNT);
    if (bus.A_Req && bus.B_Req) begin
      if (burstHold || (lastGntReg == LAST_A)) begin
        bGnt = 1'b1;
      end else begin
        aGnt = 1'b1;
      end
    end else if (bus.A_Req) begin
      aGnt = 1'b1;
    end else if (bus.B_Req) begin
      bGnt = 1'b1;
    end
    if (aGnt) begin
      lastGntNext = LAST_A;
    end else if (bGnt) begin
      lastGntNext = LAST_B;
    end
    if (bGnt && bus.B_Lock) begin
      burstCntNext = (burstCntReg >= MAX_CNT) ? MAX_CNT : burstCntReg + 4'd1;
    end
  end

  // Memory-side mux: the granted port drives the memory, otherwise everything is quiet.
  always_comb begin
    bus.Mem_Read  = 1'b0;
    bus.Mem_Write = 1'b0;
    bus.Mem_Addr  = {AW{1'b0}};
    bus.Mem_WData = {DW{1'b0}};
    if (aGnt) begin
      bus.Mem_Read  = ~bus.A_Write;
      bus.Mem_Write = bus.A_Write;
      bus.Mem_Addr  = bus.A_Addr;
      bus.Mem_WData = bus.A_WData;
    end else if (bGnt) begin
      bus.Mem_Read  = ~bus.B_Write;
      bus.Mem_Write = bus.B_Write;
      bus.Mem_Addr  = bus.B_Addr;
      bus.Mem_WData = bus.B_WData;
    end
  end

  logic [1:0] portGnt;
  logic [1:0] portWrite;

  assign portGnt   = {bGnt, aGnt};
  assign portWrite = {bus.B_Write, bus.A_Write};

  // Per-port read return path: index 0 is A, index 1 is B.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic          validReg;
    logic [DW-1:0] rdataReg;

    // Capture memory data on a granted read; valid pulses for the following cycle only.
    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        validReg <= 1'b0;
        rdataReg <= {DW{1'b0}};
      end else begin
        validReg <= portGnt[gi] & ~portWrite[gi];
        if (portGnt[gi] && !portWrite[gi]) begin
          rdataReg <= bus.Mem_RData;
        end
      end
    end
  end

  assign bus.A_Gnt   = aGnt;
  assign bus.B_Gnt   = bGnt;
  assign bus.A_Stall = bus.A_Req & ~aGnt;
  assign bus.A_Valid = g_port[0].validReg;
  assign bus.A_RData = g_port[0].rdataReg;
  assign bus.B_Valid = g_port[1].validReg;
  assign bus.B_RData = g_port[1].rdataReg;

endmodule
